// File: rtl/uart_tx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_core
//  Purpose  : UART transmitter with a small transmit FIFO. Frames are
//             start(0), 8 data bits LSB first, optional parity, stop(1).
//             Back-to-back frames follow each other with no idle gap.
//  Ports    : pclk        - clock, all state updates on its rising edge
//             prstn       - asynchronous active-low reset
//             baud_div    - bit period minus one, in pclk cycles
//             parity_en   - append a parity bit after the data bits
//             parity_odd  - 1 = odd parity, 0 = even parity
//             tx_data     - byte to enqueue
//             tx_valid    - tx_data is valid this cycle
//             tx_ready    - FIFO not full
//             uart_tx     - registered serial output, idle high
//             tx_busy     - frame in progress or FIFO non-empty
//             tx_done     - one-cycle pulse at the end of each stop bit
//             fifo_cnt    - number of bytes held in the FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          pclk,
   input  logic                          prstn,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             par_en_q, par_en_d;
   logic             par_bit_q, par_bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             uart_tx_q, uart_tx_d;
   logic             tx_done_q, tx_done_d;

   logic             push;
   logic             pop;
   logic             load_frame;
   logic             bit_end;
   logic             fifo_ne;
   logic [7:0]       head;

   // ---------------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------------
   assign tx_ready = (fifo_cnt_q != FULL_CNT);
   assign push     = tx_valid && tx_ready;
   assign fifo_ne  = (fifo_cnt_q != '0);
   assign head     = mem_q[rd_ptr_q];
   assign bit_end  = (baud_cnt_q == '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge pclk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
   end

   // ---------------------------------------------------------------------
   // Transmit FSM (next-state and registered-output values)
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      div_d      = div_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      uart_tx_d  = uart_tx_q;
      tx_done_d  = 1'b0;
      load_frame = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            uart_tx_d = 1'b1;
            if (fifo_ne) begin
               load_frame = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d    = S_DATA;
               bit_idx_d  = 3'd0;
               baud_cnt_d = div_q;
               uart_tx_d  = shift_q[0];
               shift_d    = {1'b0, shift_q[7:1]};
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_cnt_d = div_q;
               // Index wraps 7 -> 0 as the last data bit completes.
               bit_idx_d  = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  if (par_en_q) begin
                     state_d   = S_PARITY;
                     uart_tx_d = par_bit_q;
                  end else begin
                     state_d   = S_STOP;
                     uart_tx_d = 1'b1;
                  end
               end else begin
                  uart_tx_d = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_d    = S_STOP;
               baud_cnt_d = div_q;
               uart_tx_d  = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               tx_done_d = 1'b1;
               if (fifo_ne) begin
                  // Chain straight into the next start bit, no idle cycle.
                  load_frame = 1'b1;
               end else begin
                  state_d   = S_IDLE;
                  uart_tx_d = 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 1'b1;
            end
         end

         default: begin
            state_d   = S_IDLE;
            uart_tx_d = 1'b1;
         end
      endcase

      // Frame launch: configuration is sampled here so that changes made
      // mid-frame only apply from the next frame on.
      if (load_frame) begin
         pop        = 1'b1;
         state_d    = S_START;
         shift_d    = head;
         div_d      = baud_div;
         baud_cnt_d = baud_div;
         par_en_d   = parity_en;
         par_bit_d  = (^head) ^ parity_odd;
         bit_idx_d  = 3'd0;
         uart_tx_d  = 1'b0;
      end
   end

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         div_q      <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         shift_q    <= '0;
         bit_idx_q  <= 3'd0;
         uart_tx_q  <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         div_q      <= div_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         uart_tx_q  <= uart_tx_d;
         tx_done_q  <= tx_done_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign uart_tx  = uart_tx_q;
   assign tx_done  = tx_done_q;
   assign fifo_cnt = fifo_cnt_q;
   assign tx_busy  = (state_q != S_IDLE) || fifo_ne;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_core
//  Purpose  : Directed self-checking bench for uart_tx_core. Accepted bytes
//             are queued with the configuration the frame should use; a line
//             monitor decodes each frame and checks every bit cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

   localparam int DIV_W = 16;
   localparam int DEPTH = 4;

   logic             pclk       = 1'b0;
   logic             prstn      = 1'b0;
   logic [DIV_W-1:0] baud_div   = '0;
   logic             parity_en  = 1'b0;
   logic             parity_odd = 1'b0;
   logic [7:0]       tx_data    = 8'h00;
   logic             tx_valid   = 1'b0;
   logic             tx_ready;
   logic             uart_tx;
   logic             tx_busy;
   logic             tx_done;
   logic [2:0]       fifo_cnt;

   uart_tx_core #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
      .pclk       (pclk),
      .prstn      (prstn),
      .baud_div   (baud_div),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .uart_tx    (uart_tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .fifo_cnt   (fifo_cnt)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [7:0] d;
      int         div;
      bit         pen;
      bit         podd;
   } exp_t;

   exp_t sb[$];
   int   start_cyc[$];
   int   cyc         = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   frames_done = 0;
   int   done_cnt    = 0;

   always @(posedge pclk) cyc++;
   always @(negedge pclk) if (prstn === 1'b1 && tx_done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic expect_push(input logic [7:0] d);
      exp_t e;
      e.d    = d;
      e.div  = int'(baud_div);
      e.pen  = parity_en;
      e.podd = parity_odd;
      sb.push_back(e);
   endtask

   // Called at a negedge; presents one byte for exactly one rising edge.
   task automatic drive(input logic [7:0] d);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge pclk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int t = 0;
      while (frames_done < target && t < budget) begin
         @(negedge pclk);
         t++;
      end
      check("frame_timeout", frames_done, target);
   endtask

   // Line monitor: samples on the falling edge, mid-way between updates.
   initial begin
      exp_t       e;
      logic [10:0] bits;
      int         nb;
      bit         abort;
      forever begin
         @(negedge pclk);
         if (prstn === 1'b1 && uart_tx === 1'b0) begin
            start_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               check("unexpected_frame", uart_tx, 1);
               for (int t = 0; t < 200 && uart_tx !== 1'b1; t++) @(negedge pclk);
            end else begin
               e       = sb.pop_front();
               bits    = '0;
               bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) bits[i+1] = e.d[i];
               nb = 10;
               if (e.pen) begin
                  bits[9] = (^e.d) ^ e.podd;
                  nb      = 11;
               end
               bits[nb-1] = 1'b1;
               abort = 1'b0;
               for (int b = 0; b < nb && !abort; b++) begin
                  for (int c = 0; c <= e.div && !abort; c++) begin
                     if (b != 0 || c != 0) begin
                        @(negedge pclk);
                        if (prstn !== 1'b1) abort = 1'b1;
                     end
                     if (!abort)
                        check($sformatf("frame_%02h_bit%0d", e.d, b), uart_tx, bits[b]);
                  end
               end
               if (!abort) frames_done++;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int d0;
      int s0;
      int ns;

      // ---------------- reset state ----------------
      repeat (3) @(negedge pclk);
      check("rst_uart_tx",  uart_tx,  1);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_tx_busy",  tx_busy,  0);
      check("rst_tx_done",  tx_done,  0);
      check("rst_fifo_cnt", fifo_cnt, 0);
      prstn = 1'b1;
      @(negedge pclk);

      // ---------------- basic frame 0xA5, 4 cycles/bit ----------------
      baud_div = 16'd3;
      d0 = done_cnt;
      expect_push(8'hA5);
      drive(8'hA5);
      check("nobypass_uart_tx", uart_tx,  1);
      check("nobypass_cnt",     fifo_cnt, 1);
      @(negedge pclk);
      check("start_uart_tx", uart_tx,  0);
      check("start_cnt",     fifo_cnt, 0);
      check("start_busy",    tx_busy,  1);
      wait_frames(1, 100);
      repeat (2) @(negedge pclk);
      check("basic_done_pulses", done_cnt - d0, 1);
      check("basic_busy_after",  tx_busy, 0);
      check("basic_line_idle",   uart_tx, 1);

      // ---------------- parity even / odd on 0x07 ----------------
      baud_div  = 16'd1;
      parity_en = 1'b1;
      parity_odd = 1'b0;
      d0 = done_cnt;
      s0 = start_cyc.size();
      expect_push(8'h07);
      drive(8'h07);
      wait_frames(2, 100);
      repeat (3) @(negedge pclk);
      parity_odd = 1'b1;
      expect_push(8'h07);
      drive(8'h07);
      wait_frames(3, 100);
      repeat (2) @(negedge pclk);
      check("parity_done_pulses", done_cnt - d0, 2);
      check("parity_busy_after",  tx_busy, 0);
      parity_en  = 1'b0;
      parity_odd = 1'b0;

      // ---------------- full FIFO, 1 cycle/bit ----------------
      baud_div = 16'd0;
      s0 = start_cyc.size();
      for (int i = 0; i < 6; i++) begin
         tx_data  = 8'h10 + 8'(i);
         tx_valid = 1'b1;
         if (i < 5) expect_push(tx_data);
         @(negedge pclk);
         if (i == 4) begin
            check("full_cnt",   fifo_cnt, 4);
            check("full_ready", tx_ready, 0);
         end
      end
      tx_valid = 1'b0;
      check("full_drop_cnt", fifo_cnt, 4);
      for (int k = 1; k <= 4; k++) begin
         for (int t = 0; t < 40 && start_cyc.size() < s0 + 1 + k; t++) @(negedge pclk);
         check($sformatf("full_step_cnt%0d", k), fifo_cnt, 4 - k);
      end
      wait_frames(8, 100);
      for (int k = 1; k < 5; k++)
         check($sformatf("full_gap%0d", k), start_cyc[s0+k] - start_cyc[s0+k-1], 10);
      repeat (2) @(negedge pclk);
      check("full_busy_after", tx_busy, 0);

      // ---------------- mid-frame baud change 3 -> 7 ----------------
      baud_div = 16'd3;
      s0 = start_cyc.size();
      expect_push(8'h3C);
      drive(8'h3C);
      repeat (13) @(negedge pclk);
      baud_div = 16'd7;
      expect_push(8'hC3);
      drive(8'hC3);
      wait_frames(10, 300);
      check("cfg_gap", start_cyc[s0+1] - start_cyc[s0], 40);
      repeat (2) @(negedge pclk);

      // ---------------- simultaneous push and pop ----------------
      baud_div = 16'd1;
      s0 = start_cyc.size();
      expect_push(8'h21);
      tx_data = 8'h21; tx_valid = 1'b1;
      @(negedge pclk);
      expect_push(8'h42);
      tx_data = 8'h42;
      @(negedge pclk);
      expect_push(8'h63);
      tx_data = 8'h63;
      @(negedge pclk);
      tx_valid = 1'b0;
      check("simul_pre_cnt", fifo_cnt, 2);
      repeat (18) @(negedge pclk);
      check("simul_edge_cnt", fifo_cnt, 2);
      expect_push(8'h84);
      drive(8'h84);
      check("simul_post_cnt",  fifo_cnt, 2);
      check("simul_next_start", uart_tx, 0);
      wait_frames(14, 300);
      for (int k = 1; k < 4; k++)
         check($sformatf("simul_gap%0d", k), start_cyc[s0+k] - start_cyc[s0+k-1], 20);
      repeat (2) @(negedge pclk);

      // ---------------- reset mid-frame ----------------
      baud_div = 16'd3;
      expect_push(8'hF0);
      tx_data = 8'hF0; tx_valid = 1'b1;
      @(negedge pclk);
      expect_push(8'h0F);
      tx_data = 8'h0F;
      @(negedge pclk);
      expect_push(8'h55);
      tx_data = 8'h55;
      @(negedge pclk);
      tx_valid = 1'b0;
      check("rstmid_queued", fifo_cnt, 2);
      repeat (10) @(negedge pclk);
      #2 prstn = 1'b0;
      #1;
      check("rstmid_uart_tx", uart_tx,  1);
      check("rstmid_cnt",     fifo_cnt, 0);
      check("rstmid_busy",    tx_busy,  0);
      check("rstmid_ready",   tx_ready, 1);
      sb.delete();
      ns = start_cyc.size();
      repeat (2) @(negedge pclk);
      prstn = 1'b1;
      repeat (60) @(negedge pclk);
      check("rstmid_no_resume", start_cyc.size(), ns);
      check("rstmid_line_idle", uart_tx, 1);

      // ---------------- accept on first edge after release ----------------
      prstn = 1'b0;
      repeat (2) @(negedge pclk);
      prstn = 1'b1;
      expect_push(8'h5A);
      drive(8'h5A);
      check("release_accept_cnt", fifo_cnt, 1);
      wait_frames(15, 100);
      repeat (2) @(negedge pclk);
      check("release_busy_after", tx_busy, 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, a power of two, minimum 2.
REQ-003 SHALL have port pclk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port prstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port baud_div, input, DIV_W bits: bit period minus one, in pclk cycles.
REQ-006 SHALL have port parity_en, input, 1 bit: when 1, a parity bit follows the data bits.
REQ-007 SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-008 SHALL have port tx_data, input, 8 bits: byte to enqueue.
REQ-009 SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-010 SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte (not full).
REQ-011 SHALL have port uart_tx, output, 1 bit: registered serial line, idle high.
REQ-012 SHALL have port tx_busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-013 SHALL have port tx_done, output, 1 bit: single-cycle pulse at the end of each stop bit.
REQ-014 SHALL have port fifo_cnt, output, log2(FIFO_DEPTH)+1 bits: number of bytes in the FIFO.

Function
REQ-015 SHALL accept a byte on any rising edge where tx_valid and tx_ready are both 1.
- tx_ready = (fifo_cnt != FIFO_DEPTH), registered-state based.
REQ-016 SHALL ignore tx_valid while full: the byte is dropped and the FIFO is unchanged.
REQ-017 SHALL update fifo_cnt correctly on a simultaneous push and pop: the count is unchanged and the data order is preserved.
REQ-018 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 SHALL, in IDLE with the FIFO non-empty, on one edge:
- pop the head byte into the shift register;
- latch baud_div, parity_en and parity_odd;
- set uart_tx=0;
- go to START.
REQ-021 SHALL produce no bypass path, so uart_tx falls on the first edge after the accepting edge when IDLE with an empty FIFO.
REQ-022 SHALL hold each bit for exactly latched baud_div+1 cycles, using a down-counter reloaded at each bit boundary; baud_div=0 gives 1 cycle per bit.
REQ-023 SHALL send the frame in this order:
- start bit 0;
- 8 data bits, LSB first (DATA uses a 3-bit index, wrapping from 7 to the next state);
- parity bit if latched parity_en is set;
- one stop bit 1.
REQ-024 SHALL compute parity as XOR of the 8 data bits, inverted when parity_odd is set.
REQ-025 SHALL make a mid-frame change of baud_div, parity_en or parity_odd take effect only at the next frame.
REQ-026 SHALL, at the last cycle of STOP:
- pulse tx_done for 1 cycle;
- if the FIFO is non-empty, pop, drive uart_tx=0 and enter START on the same edge (no idle gap);
- otherwise return to IDLE with uart_tx=1.
REQ-027 SHALL make the frame length equal to (10 + parity_en) × (baud_div+1) cycles.
REQ-028 SHALL keep tx_busy = (state != IDLE) || (fifo_cnt != 0).

Reset
REQ-029 SHALL, when prstn=0, immediately and asynchronously set:
- uart_tx=1, tx_done=0, tx_busy=0;
- fifo_cnt=0, tx_ready=1;
- state to IDLE, and clear the pointers, counter, shift register and latched configuration.
REQ-030 SHALL, on reset mid-frame, abort the frame (the line returns high at once) and flush all FIFO contents; nothing resumes after release.
REQ-031 SHALL accept a byte on the first rising edge after prstn deasserts.

Verification
REQ-032 SHALL cover a basic frame: baud_div=3, parity off, push 0xA5 -> uart_tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total, one tx_done pulse, tx_busy low afterwards.
REQ-033 SHALL cover parity: baud_div=1, parity_en=1, parity_odd=0, push 0x07 -> parity bit 1, frame 22 cycles; with parity_odd=1 -> parity bit 0.
REQ-034 SHALL cover a full FIFO: baud_div=0, push 6 bytes back-to-back -> the first is popped, 4 are queued, and tx_ready goes low; the 6th byte is dropped while full; 5 frames are sent contiguously with no idle cycle; fifo_cnt steps 4→0.
REQ-035 SHALL cover a mid-frame config change: change baud_div 3→7 during DATA -> the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
REQ-036 SHALL cover reset mid-frame: assert prstn=0 during DATA with 2 bytes queued -> uart_tx=1 and fifo_cnt=0 immediately, and no frame follows release.
REQ-037 SHALL cover simultaneous push and pop: push at the same edge as the STOP-end pop with fifo_cnt=2 -> fifo_cnt stays 2 and bytes are sent in order.
